// File: rtl/fifo_if.sv
// Producer/consumer bundle for fifo_sync_param: write side, read side and status.
// Combinational only: no latency of its own.
// Backpressure is carried by the full/empty status that the FIFO drives back.
interface fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, din, rd,
        input  dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  wr, din, rd,
        output dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Latency: dout is registered, one cycle after an accepted read; flags decode the registered count.
// Backpressure: writes while full and reads while empty are dropped and reported by a one-cycle pulse.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic is_empty, is_full, wr_acc, rd_acc;

    // Full and empty come from the count so equal pointers are never ambiguous.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign wr_acc   = bus.wr && !is_full;
    assign rd_acc   = bus.rd && !is_empty;

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = bus.wr && is_full;
        underflow_d  = bus.rd && is_empty;

        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d       = rptr_q + AW'(1);
            dout_d       = mem[rptr_q];
            dout_valid_d = 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.count        = count_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
